// File: rtl/morse_pkg.sv
// Shared constants and state encoding for the Morse transmitter sequencer
// and the character memory it drives.
package morse_pkg;

  localparam int unsigned MAX_CHARS = 12;
  localparam int unsigned PATTERN_W = 27;
  localparam int unsigned ADDR_W    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    TX    = 2'd2,
    DONE  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/morse_unit_tick.sv
// Morse unit-time prescaler: while enabled, emits a registered one-cycle tick
// every UNIT_DIV cycles, the first one UNIT_DIV-1 cycles after enable.
module morse_unit_tick #(
  parameter int unsigned UNIT_DIV = 25_000_000
) (
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned CNT_W = (UNIT_DIV > 1) ? $clog2(UNIT_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(UNIT_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(UNIT_DIV - 2);

  logic [CNT_W-1:0] cnt;

  // tick is registered, so it is raised one count early to land on CNT_LAST
  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (en) begin
      cnt  <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
      tick <= (cnt == CNT_PRE);
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/morse_tx_ctrl.sv
// Morse transmitter sequencer: loads encoded characters into the character
// memory, then replays them one unit tick per pattern bit on a send request.
module morse_tx_ctrl #(
  parameter int unsigned MAX_CHARS = morse_pkg::MAX_CHARS,
  parameter int unsigned PATTERN_W = morse_pkg::PATTERN_W,
  parameter int unsigned UNIT_DIV  = 25_000_000
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         char_valid,
  input  logic [PATTERN_W-1:0]         char_code,
  output logic                         char_ready,
  input  logic                         send,
  input  logic                         clear,
  output logic                         mem_we,
  output logic [morse_pkg::ADDR_W-1:0] mem_addr,
  output logic [PATTERN_W-1:0]         mem_data,
  output logic                         mem_start,
  output logic                         unit_tick,
  output logic                         busy,
  output logic                         done,
  output logic [morse_pkg::ADDR_W-1:0] char_count
);

  import morse_pkg::*;

  localparam int unsigned BIT_W = $clog2(PATTERN_W);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(PATTERN_W - 1);
  localparam logic [ADDR_W-1:0] CNT_MAX  = ADDR_W'(MAX_CHARS);

  tx_state_t        state;
  logic [BIT_W-1:0] bit_cnt;
  logic             accept;

  assign char_ready = !RST && (state == IDLE) && (char_count < CNT_MAX) && !send && !clear;
  assign accept     = char_valid && char_ready;

  // Prescaler runs only in TX; any other state or an abort holds it cleared
  morse_unit_tick #(
    .UNIT_DIV (UNIT_DIV)
  ) u_unit_tick (
    .CLK  (CLK),
    .RST  (RST),
    .clr  ((state != TX) || clear),
    .en   (state == TX),
    .tick (unit_tick)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      mem_start  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      char_count <= '0;
      bit_cnt    <= '0;
    end else begin
      mem_we    <= 1'b0;
      mem_start <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (clear) begin
            char_count <= '0;
          end else if (send && (char_count != '0)) begin
            state     <= START;
            mem_start <= 1'b1;
            mem_addr  <= '0;
            busy      <= 1'b1;
            bit_cnt   <= '0;
          end else if (accept) begin
            mem_we     <= 1'b1;
            mem_addr   <= char_count;
            mem_data   <= char_code;
            char_count <= char_count + ADDR_W'(1);
          end
        end
        START: begin
          bit_cnt <= '0;
          if (clear) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= TX;
          end
        end
        TX: begin
          // Abort keeps char_count so the same message can be resent
          if (clear) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (unit_tick) begin
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              if (mem_addr == char_count - ADDR_W'(1)) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                mem_addr <= mem_addr + ADDR_W'(1);
              end
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
        end
        DONE: begin
          state      <= IDLE;
          char_count <= '0;
          mem_addr   <= '0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_morse_tx_ctrl.sv
// Directed bench for morse_tx_ctrl: vector tables for load/ignore/priority/
// overflow, hand-written sequences for a full send and an abort.
module tb_morse_tx_ctrl;

  localparam int unsigned UNIT_DIV  = 4;
  localparam int unsigned PATTERN_W = 27;
  localparam int unsigned MAX_CHARS = 12;

  logic                 CLK = 1'b0;
  logic                 RST;
  logic                 char_valid;
  logic [PATTERN_W-1:0] char_code;
  logic                 char_ready;
  logic                 send;
  logic                 clear;
  logic                 mem_we;
  logic [3:0]           mem_addr;
  logic [PATTERN_W-1:0] mem_data;
  logic                 mem_start;
  logic                 unit_tick;
  logic                 busy;
  logic                 done;
  logic [3:0]           char_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        valid;
    logic [26:0] code;
    logic        snd;
    logic        clr;
    logic        exp_ready;
    logic        exp_we;
    logic [3:0]  exp_addr;
    logic [26:0] exp_data;
    logic [3:0]  exp_count;
    logic        exp_start;
  } vec_t;

  vec_t qa[$];
  vec_t qb[$];

  morse_tx_ctrl #(
    .MAX_CHARS (MAX_CHARS),
    .PATTERN_W (PATTERN_W),
    .UNIT_DIV  (UNIT_DIV)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .char_valid (char_valid),
    .char_code  (char_code),
    .char_ready (char_ready),
    .send       (send),
    .clear      (clear),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_start  (mem_start),
    .unit_tick  (unit_tick),
    .busy       (busy),
    .done       (done),
    .char_count (char_count)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [26:0] c, input logic s,
                              input logic cl, input logic er, input logic ew,
                              input logic [3:0] ea, input logic [26:0] ed,
                              input logic [3:0] ec, input logic es);
    vec_t r;
    r.valid = v; r.code = c; r.snd = s; r.clr = cl; r.exp_ready = er;
    r.exp_we = ew; r.exp_addr = ea; r.exp_data = ed; r.exp_count = ec; r.exp_start = es;
    return r;
  endfunction

  task automatic apply_vec(input string tag, input int idx, input vec_t v);
    @(negedge CLK);
    char_valid = v.valid; char_code = v.code; send = v.snd; clear = v.clr;
    #1;
    check($sformatf("%s%0d ready", tag, idx), 32'(char_ready), 32'(v.exp_ready));
    @(posedge CLK); #1;
    check($sformatf("%s%0d we", tag, idx),    32'(mem_we),     32'(v.exp_we));
    check($sformatf("%s%0d addr", tag, idx),  32'(mem_addr),   32'(v.exp_addr));
    check($sformatf("%s%0d data", tag, idx),  32'(mem_data),   32'(v.exp_data));
    check($sformatf("%s%0d count", tag, idx), 32'(char_count), 32'(v.exp_count));
    check($sformatf("%s%0d start", tag, idx), 32'(mem_start),  32'(v.exp_start));
    check($sformatf("%s%0d busy", tag, idx),  32'(busy),       32'(1'b0));
  endtask

  task automatic zero_inputs();
    @(negedge CLK);
    char_valid = 1'b0; char_code = '0; send = 1'b0; clear = 1'b0;
  endtask

  initial begin
    int tx_cycles, ticks, tick_errs, addr_errs, done_errs, start_errs;

    // Load two characters, then idle
    qa.push_back(mk(1'b1, 27'h2CAA8AB, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 27'h2CAA8AB, 4'd1, 1'b0));
    qa.push_back(mk(1'b1, 27'h51A5AD6, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 27'h51A5AD6, 4'd2, 1'b0));
    qa.push_back(mk(1'b0, 27'h0,       1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 27'h51A5AD6, 4'd2, 1'b0));

    // Send on empty buffer, load 3, send+clear priority, overflow, clear, load 2
    qb.push_back(mk(1'b0, 27'h0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 27'h51A5AD6, 4'd0, 1'b0));
    qb.push_back(mk(1'b0, 27'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 27'h51A5AD6, 4'd0, 1'b0));
    for (int i = 0; i < 3; i++)
      qb.push_back(mk(1'b1, 27'(i + 1), 1'b0, 1'b0, 1'b1, 1'b1, 4'(i), 27'(i + 1), 4'(i + 1), 1'b0));
    qb.push_back(mk(1'b0, 27'h0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 27'h3, 4'd0, 1'b0));
    qb.push_back(mk(1'b0, 27'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 27'h3, 4'd0, 1'b0));
    for (int i = 0; i < 12; i++)
      qb.push_back(mk(1'b1, 27'(32'h100 + i), 1'b0, 1'b0, 1'b1, 1'b1, 4'(i), 27'(32'h100 + i), 4'(i + 1), 1'b0));
    qb.push_back(mk(1'b1, 27'h10C, 1'b0, 1'b0, 1'b0, 1'b0, 4'd11, 27'h10B, 4'd12, 1'b0));
    qb.push_back(mk(1'b1, 27'h10C, 1'b0, 1'b0, 1'b0, 1'b0, 4'd11, 27'h10B, 4'd12, 1'b0));
    qb.push_back(mk(1'b0, 27'h0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd11, 27'h10B, 4'd0, 1'b0));
    qb.push_back(mk(1'b1, 27'h2CAA8AB, 1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 27'h2CAA8AB, 4'd1, 1'b0));
    qb.push_back(mk(1'b1, 27'h51A5AD6, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 27'h51A5AD6, 4'd2, 1'b0));

    RST = 1'b1; char_valid = 1'b0; char_code = '0; send = 1'b0; clear = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    check("rst we",    32'(mem_we),     32'(1'b0));
    check("rst addr",  32'(mem_addr),   32'(4'd0));
    check("rst data",  32'(mem_data),   32'(27'h0));
    check("rst start", 32'(mem_start),  32'(1'b0));
    check("rst tick",  32'(unit_tick),  32'(1'b0));
    check("rst busy",  32'(busy),       32'(1'b0));
    check("rst done",  32'(done),       32'(1'b0));
    check("rst count", 32'(char_count), 32'(4'd0));
    check("rst ready", 32'(char_ready), 32'(1'b0));
    @(negedge CLK); RST = 1'b0;
    @(posedge CLK); #1;
    check("post-rst ready", 32'(char_ready), 32'(1'b1));

    foreach (qa[i]) apply_vec("load", i, qa[i]);

    // Full transmission of the two loaded characters
    @(negedge CLK);
    char_valid = 1'b0; send = 1'b1; clear = 1'b0;
    #1 check("send ready", 32'(char_ready), 32'(1'b0));
    @(posedge CLK); #1;
    check("start pulse", 32'(mem_start), 32'(1'b1));
    check("start busy",  32'(busy),      32'(1'b1));
    check("start addr",  32'(mem_addr),  32'(4'd0));
    @(negedge CLK); send = 1'b0;
    tx_cycles = 0; ticks = 0; tick_errs = 0; addr_errs = 0; done_errs = 0; start_errs = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge CLK); #1;
      if (!busy) break;
      if (mem_start) start_errs++;
      if (unit_tick != ((tx_cycles % 4) == 3)) tick_errs++;
      if (unit_tick) ticks++;
      if (mem_addr != ((tx_cycles < 108) ? 4'd0 : 4'd1)) addr_errs++;
      if (done) done_errs++;
      tx_cycles++;
    end
    check("tx cycles",     32'(tx_cycles),  32'd216);
    check("tx ticks",      32'(ticks),      32'd54);
    check("tick spacing",  32'(tick_errs),  32'd0);
    check("tx addr",       32'(addr_errs),  32'd0);
    check("tx early done", 32'(done_errs),  32'd0);
    check("start width",   32'(start_errs), 32'd0);
    check("done pulse",    32'(done),       32'(1'b1));
    check("done busy",     32'(busy),       32'(1'b0));
    check("done tick",     32'(unit_tick),  32'(1'b0));
    @(posedge CLK); #1;
    check("after done pulse", 32'(done),       32'(1'b0));
    check("after done count", 32'(char_count), 32'(4'd0));
    check("after done addr",  32'(mem_addr),   32'(4'd0));
    check("after done ready", 32'(char_ready), 32'(1'b1));

    foreach (qb[i]) apply_vec("seq", i, qb[i]);

    // Abort 50 cycles into TX with two characters loaded
    @(negedge CLK);
    char_valid = 1'b0; char_code = '0; send = 1'b1; clear = 1'b0;
    @(posedge CLK); #1;
    check("abort start", 32'(mem_start), 32'(1'b1));
    @(negedge CLK); send = 1'b0;
    repeat (51) @(posedge CLK);
    @(negedge CLK);
    check("abort pre busy", 32'(busy), 32'(1'b1));
    clear = 1'b1;
    @(posedge CLK); #1;
    check("abort busy",  32'(busy),       32'(1'b0));
    check("abort done",  32'(done),       32'(1'b0));
    check("abort tick",  32'(unit_tick),  32'(1'b0));
    check("abort count", 32'(char_count), 32'(4'd2));
    @(negedge CLK); clear = 1'b0;
    #1 check("abort ready", 32'(char_ready), 32'(1'b1));
    @(posedge CLK); #1;
    check("abort done2",  32'(done),       32'(1'b0));
    check("abort tick2",  32'(unit_tick),  32'(1'b0));
    check("abort busy2",  32'(busy),       32'(1'b0));
    check("abort count2", 32'(char_count), 32'(4'd2));
    zero_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/morse_tx_ctrl.md
# morse_tx_ctrl

Sequencer for the Morse transmitter's character memory. It accepts up to MAX_CHARS pre-encoded character patterns over a valid/ready handshake and writes each one into the memory slot addressed by the character counter. On a send request it pulses the memory's start input, generates the Morse unit-time tick and steps the slot address one character at a time. It reports busy while sending and pulses done when the last character has finished. The block sits between the keyboard/encoder front end and the memory/serializer datapath.

## Interface
- MAX_CHARS, 12: number of memory slots (character capacity).
- PATTERN_W, 27: bits per encoded character pattern; one unit tick per bit.
- UNIT_DIV, 25_000_000: CLK cycles per Morse unit. Must be at least 2.
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- char_valid  in  1  encoder offers a pattern.
- char_code  in  PATTERN_W  encoded pattern.
- char_ready  out  1  pattern accepted when char_valid and char_ready are both high at a rising edge.
- send  in  1  start-transmission request (level sampled each cycle).
- clear  in  1  empty the buffer, or abort an active transmission.
- mem_we  out  1  one-cycle memory write strobe.
- mem_addr  out  4  memory slot index (conta_carac).
- mem_data  out  PATTERN_W  memory write data (datos).
- mem_start  out  1  one-cycle start pulse to the memory/serializer.
- unit_tick  out  1  one-cycle pulse per Morse unit while transmitting.
- busy  out  1  high in states START and TX.
- done  out  1  one-cycle pulse at the end of a completed transmission.
- char_count  out  4  number of stored characters, 0..MAX_CHARS.

## Operation
- FSM states: IDLE, START, TX, DONE. Reset state is IDLE.
- Reset values: all registered outputs are 0. This covers mem_*, unit_tick, done, char_count and the internal counters. busy is 0.
- char_ready is combinational: high when state is IDLE, char_count < MAX_CHARS, send is low and clear is low.
- IDLE, on a handshake:
  - mem_addr <= char_count; mem_data <= char_code; mem_we <= 1 for exactly one cycle.
  - char_count increments.
- IDLE, on clear: char_count <= 0. clear has priority over send.
- IDLE, on send with char_count > 0: go to START. send with char_count = 0 is ignored.
- START (1 cycle): mem_start = 1, mem_addr = 0. Clear the prescaler and bit counter, then go to TX.
- TX:
  - The prescaler counts 0..UNIT_DIV-1 and asserts unit_tick on the cycle it reaches UNIT_DIV-1.
  - The bit counter advances on each tick, 0..PATTERN_W-1.
  - On the tick where bit = PATTERN_W-1: if mem_addr = char_count-1, go to DONE. Otherwise increment mem_addr and reset the bit counter.
- DONE (1 cycle): done = 1, char_count <= 0, mem_addr <= 0, then go to IDLE.
- clear during START or TX aborts the transmission:
  - Next state is IDLE; no done pulse; unit_tick stops.
  - char_count is retained, so the message can be resent.
- send during START, TX or DONE is ignored.
- char_valid outside IDLE is not accepted. A held pattern stays pending.
- At char_count = MAX_CHARS, char_ready is low and nothing is overwritten.
- Counter widths: prescaler is clog2(UNIT_DIV) bits; bit counter is clog2(PATTERN_W) bits. Both wrap to 0 explicitly and never by overflow.

## Timing
- Write: handshake at edge k → mem_we, mem_addr and mem_data valid in cycle k+1; char_count updated at k+1.
- send sampled at edge k → mem_start high in cycle k+1 (START); TX begins at cycle k+2.
- First unit_tick: UNIT_DIV-1 cycles after TX entry. Ticks are then spaced exactly UNIT_DIV cycles apart.
- TX duration is char_count × PATTERN_W × UNIT_DIV cycles. done follows the cycle after the final tick.
- busy is high from the START cycle through the last TX cycle, and low in DONE.
- Abort: clear at edge k → IDLE at k+1; busy low at k+1.

## Structure
- Package morse_pkg holds:
  - state typedef (IDLE/START/TX/DONE);
  - MAX_CHARS, PATTERN_W and ADDR_W constants, shared with the memory block.
- Sub-module morse_unit_tick: prescaler with inputs CLK, RST, clr, en and output tick. Instantiated once.
- All remaining logic (FSM, slot counter, bit counter) lives in morse_tx_ctrl.

## Test plan
All scenarios use UNIT_DIV=4, PATTERN_W=27, MAX_CHARS=12.
- Reset: RST high for 4 cycles → all outputs 0 and char_count=0. Cycle after release → char_ready=1.
- Load: write 27'h2CAA8AB then 27'h51A5AD6.
  - mem_we pulses twice: addr 0 with 27'h2CAA8AB, then addr 1 with 27'h51A5AD6.
  - char_count=2.
- Send with 2 chars loaded:
  - mem_start for 1 cycle, then busy for 216 TX cycles (2×27×4).
  - 54 unit_ticks; mem_addr=0 for the first 108 cycles, then 1.
  - done pulse, after which char_count=0.
- Overflow: offer 13 consecutive patterns.
  - 12 are accepted and char_ready drops at char_count=12.
  - The 13th stays pending with no mem_we.
- Abort and ignore: send with char_count=0 → no mem_start. Load 2, send, assert clear 50 cycles into TX → busy low next cycle, no done, char_count=2.
- Priority: send and clear high in the same IDLE cycle with char_count=3 → char_count=0, no mem_start, busy stays 0.
